// File: rtl/hazard_if.sv
// Pipeline-side signal bundle of the MIPS hazard controller.
// master: the pipeline datapath, which supplies register ids and control bits.
// slave:  hazard_ctrl, which returns forwarding selects, stall/flush enables and status.
interface hazard_if;
  logic [4:0] Rs_D;
  logic [4:0] Rt_D;
  logic [4:0] Rs_E;
  logic [4:0] Rt_E;
  logic [4:0] WriteReg_E;
  logic [4:0] WriteReg_M;
  logic [4:0] WriteReg_W;
  logic       RegWrite_E;
  logic       RegWrite_M;
  logic       RegWrite_W;
  logic       MemtoReg_E;
  logic       MemtoReg_M;
  logic       Branch_D;
  logic [1:0] PCSrc_D;
  logic       dmem_wait_M;
  logic       ForwardA_D;
  logic       ForwardB_D;
  logic [1:0] ForwardA_E;
  logic [1:0] ForwardB_E;
  logic       StallF;
  logic       StallD;
  logic       StallE;
  logic       StallM;
  logic       FlushD;
  logic       FlushE;
  logic       FlushW;
  logic [1:0] hz_state;
  logic       wait_timeout;

  modport master (
    output Rs_D, Rt_D, Rs_E, Rt_E, WriteReg_E, WriteReg_M, WriteReg_W,
           RegWrite_E, RegWrite_M, RegWrite_W, MemtoReg_E, MemtoReg_M,
           Branch_D, PCSrc_D, dmem_wait_M,
    input  ForwardA_D, ForwardB_D, ForwardA_E, ForwardB_E,
           StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           hz_state, wait_timeout
  );

  modport slave (
    input  Rs_D, Rt_D, Rs_E, Rt_E, WriteReg_E, WriteReg_M, WriteReg_W,
           RegWrite_E, RegWrite_M, RegWrite_W, MemtoReg_E, MemtoReg_M,
           Branch_D, PCSrc_D, dmem_wait_M,
    output ForwardA_D, ForwardB_D, ForwardA_E, ForwardB_E,
           StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           hz_state, wait_timeout
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and pipeline-sequencing controller for the 5-stage MIPS pipeline.
// Forwarding selects and stall/flush enables are combinational; the hazard
// class is registered into hz_state and a watchdog flags endless memory waits.
// Optional build macro HAZARD_PERF_CNT_EN adds stall_cycles / flush_count.
module hazard_ctrl #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  hazard_if.slave     hif
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
`endif
);

  typedef enum logic [1:0] {
    HZ_RUN     = 2'd0,
    HZ_LDUSE   = 2'd1,
    HZ_BRSTALL = 2'd2,
    HZ_MEMWAIT = 2'd3
  } hz_e;

  localparam logic [7:0] MAX_W8 = 8'(MAX_WAIT);

  hz_e        hz_state_d, hz_state_q;
  logic [7:0] wait_cnt_d, wait_cnt_q;
  logic       wait_timeout_d, wait_timeout_q;
  logic       ld_use, br_dep_e, br_dep_m;

  // Operand forwarding; register 0 never forwards, memory stage beats writeback.
  always_comb begin
    hif.ForwardA_D = (hif.Rs_D != '0) && (hif.Rs_D == hif.WriteReg_M) && hif.RegWrite_M;
    hif.ForwardB_D = (hif.Rt_D != '0) && (hif.Rt_D == hif.WriteReg_M) && hif.RegWrite_M;

    hif.ForwardA_E = 2'b00;
    if ((hif.Rs_E != '0) && (hif.Rs_E == hif.WriteReg_M) && hif.RegWrite_M)
      hif.ForwardA_E = 2'b10;
    else if ((hif.Rs_E != '0) && (hif.Rs_E == hif.WriteReg_W) && hif.RegWrite_W)
      hif.ForwardA_E = 2'b01;

    hif.ForwardB_E = 2'b00;
    if ((hif.Rt_E != '0) && (hif.Rt_E == hif.WriteReg_M) && hif.RegWrite_M)
      hif.ForwardB_E = 2'b10;
    else if ((hif.Rt_E != '0) && (hif.Rt_E == hif.WriteReg_W) && hif.RegWrite_W)
      hif.ForwardB_E = 2'b01;
  end

  // Hazard classification in priority order and the stall/flush enables it implies.
  always_comb begin
    ld_use   = hif.MemtoReg_E && (hif.WriteReg_E != '0) &&
               ((hif.WriteReg_E == hif.Rs_D) || (hif.WriteReg_E == hif.Rt_D));
    br_dep_e = hif.RegWrite_E && (hif.WriteReg_E != '0) &&
               ((hif.WriteReg_E == hif.Rs_D) || (hif.WriteReg_E == hif.Rt_D));
    br_dep_m = hif.MemtoReg_M && (hif.WriteReg_M != '0) &&
               ((hif.WriteReg_M == hif.Rs_D) || (hif.WriteReg_M == hif.Rt_D));

    hz_state_d = HZ_RUN;
    if (hif.dmem_wait_M)
      hz_state_d = HZ_MEMWAIT;
    else if (ld_use)
      hz_state_d = HZ_LDUSE;
    else if (hif.Branch_D && (br_dep_e || br_dep_m))
      hz_state_d = HZ_BRSTALL;

    hif.StallF = 1'b0;
    hif.StallD = 1'b0;
    hif.StallE = 1'b0;
    hif.StallM = 1'b0;
    hif.FlushD = 1'b0;
    hif.FlushE = 1'b0;
    hif.FlushW = 1'b0;
    unique case (hz_state_d)
      HZ_MEMWAIT: begin
        hif.StallF = 1'b1;
        hif.StallD = 1'b1;
        hif.StallE = 1'b1;
        hif.StallM = 1'b1;
        hif.FlushW = 1'b1;
      end
      HZ_LDUSE, HZ_BRSTALL: begin
        hif.StallF = 1'b1;
        hif.StallD = 1'b1;
        hif.FlushE = 1'b1;
      end
      default: begin
        // Redirects are only honoured when decode is not held.
        hif.FlushD = (hif.PCSrc_D != 2'b00);
      end
    endcase
  end

  // Watchdog next state: count consecutive wait cycles, saturate, latch the timeout.
  always_comb begin
    wait_cnt_d     = '0;
    wait_timeout_d = wait_timeout_q;
    if (hz_state_d == HZ_MEMWAIT) begin
      wait_cnt_d = (wait_cnt_q == MAX_W8) ? wait_cnt_q : wait_cnt_q + 8'd1;
      if (wait_cnt_q == MAX_W8 - 8'd1)
        wait_timeout_d = 1'b1;
    end
  end

  // Hazard class and watchdog registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hz_state_q     <= HZ_RUN;
      wait_cnt_q     <= '0;
      wait_timeout_q <= 1'b0;
    end else begin
      hz_state_q     <= hz_state_d;
      wait_cnt_q     <= wait_cnt_d;
      wait_timeout_q <= wait_timeout_d;
    end
  end

  assign hif.hz_state     = hz_state_q;
  assign hif.wait_timeout = wait_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_d, stall_cycles_q;
  logic [15:0] flush_count_d, flush_count_q;

  // Performance counters: wrap naturally at their width.
  always_comb begin
    stall_cycles_d = stall_cycles_q + {31'd0, hif.StallF};
    flush_count_d  = flush_count_q + {15'd0, (hif.FlushD | hif.FlushE)};
  end

  // Performance counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (MAX_WAIT=4): directed scenarios followed
// by randomized traffic, all checked against a rule-level reference model.
module tb_hazard_ctrl;
  localparam int MAXW = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  hazard_if hif ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
  hazard_ctrl #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset), .hif(hif),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );
`else
  hazard_ctrl #(.MAX_WAIT(MAXW)) dut (.clk(clk), .reset(reset), .hif(hif));
`endif

  always #5 clk = ~clk;

  // Reference model state
  int          exp_hz;
  int          exp_cnt;
  bit          exp_to;
  logic [31:0] exp_stalls;
  logic [15:0] exp_flushes;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic bit dep(input logic [4:0] dst);
    return (dst != 0) && (dst == hif.Rs_D || dst == hif.Rt_D);
  endfunction

  // Hazard class from the rules: 3 memwait, 1 load-use, 2 branch stall, 0 run.
  function automatic int model_class();
    if (hif.dmem_wait_M) return 3;
    if (hif.MemtoReg_E && dep(hif.WriteReg_E)) return 1;
    if (hif.Branch_D && ((hif.RegWrite_E && dep(hif.WriteReg_E)) ||
                         (hif.MemtoReg_M && dep(hif.WriteReg_M)))) return 2;
    return 0;
  endfunction

  function automatic int model_fwd_e(input logic [4:0] src);
    if (src != 0 && src == hif.WriteReg_M && hif.RegWrite_M) return 2;
    if (src != 0 && src == hif.WriteReg_W && hif.RegWrite_W) return 1;
    return 0;
  endfunction

  task automatic check_comb();
    int cls;
    cls = model_class();
    chk("ForwardA_D", 32'(hif.ForwardA_D),
        32'(hif.Rs_D != 0 && hif.Rs_D == hif.WriteReg_M && hif.RegWrite_M));
    chk("ForwardB_D", 32'(hif.ForwardB_D),
        32'(hif.Rt_D != 0 && hif.Rt_D == hif.WriteReg_M && hif.RegWrite_M));
    chk("ForwardA_E", 32'(hif.ForwardA_E), 32'(model_fwd_e(hif.Rs_E)));
    chk("ForwardB_E", 32'(hif.ForwardB_E), 32'(model_fwd_e(hif.Rt_E)));
    chk("StallF", 32'(hif.StallF), 32'(cls != 0));
    chk("StallD", 32'(hif.StallD), 32'(cls != 0));
    chk("StallE", 32'(hif.StallE), 32'(cls == 3));
    chk("StallM", 32'(hif.StallM), 32'(cls == 3));
    chk("FlushD", 32'(hif.FlushD), 32'(cls == 0 && hif.PCSrc_D != 0));
    chk("FlushE", 32'(hif.FlushE), 32'(cls == 1 || cls == 2));
    chk("FlushW", 32'(hif.FlushW), 32'(cls == 3));
  endtask

  task automatic check_seq();
    chk("hz_state", 32'(hif.hz_state), 32'(exp_hz));
    chk("wait_timeout", 32'(hif.wait_timeout), 32'(exp_to));
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cycles", stall_cycles, exp_stalls);
    chk("flush_count", 32'(flush_count), 32'(exp_flushes));
`endif
  endtask

  // Inputs are already applied; check combinational outputs, clock once, check registers.
  task automatic cycle();
    int cls;
    #1;
    check_comb();
    cls = model_class();
    @(posedge clk);
    if (!reset) begin
      if (cls == 3) begin
        if (exp_cnt == MAXW - 1) exp_to = 1'b1;
        if (exp_cnt < MAXW) exp_cnt++;
      end else begin
        exp_cnt = 0;
      end
      if (cls != 0) exp_stalls++;
      if (cls == 1 || cls == 2 || (cls == 0 && hif.PCSrc_D != 0)) exp_flushes++;
      exp_hz = cls;
    end
    #1;
    check_seq();
  endtask

  task automatic model_reset();
    exp_hz = 0; exp_cnt = 0; exp_to = 1'b0; exp_stalls = '0; exp_flushes = '0;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_seq();
    #5;
    reset = 1'b0;
  endtask

  task automatic clear_inputs();
    hif.Rs_D = '0; hif.Rt_D = '0; hif.Rs_E = '0; hif.Rt_E = '0;
    hif.WriteReg_E = '0; hif.WriteReg_M = '0; hif.WriteReg_W = '0;
    hif.RegWrite_E = 1'b0; hif.RegWrite_M = 1'b0; hif.RegWrite_W = 1'b0;
    hif.MemtoReg_E = 1'b0; hif.MemtoReg_M = 1'b0; hif.Branch_D = 1'b0;
    hif.PCSrc_D = '0; hif.dmem_wait_M = 1'b0;
  endtask

  task automatic set_load_use();
    hif.MemtoReg_E = 1'b1; hif.WriteReg_E = 5'd8; hif.Rt_D = 5'd8;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    model_reset();
    #2;
    check_seq();
    #6;
    reset = 1'b0;
    cycle();

    // Forwarding priority and register-0 exclusion
    hif.Rs_E = 5'd5; hif.WriteReg_M = 5'd5; hif.RegWrite_M = 1'b1;
    hif.WriteReg_W = 5'd5; hif.RegWrite_W = 1'b1;
    #1 chk("fwd_m_priority", 32'(hif.ForwardA_E), 32'd2);
    hif.RegWrite_M = 1'b0;
    #1 chk("fwd_w", 32'(hif.ForwardA_E), 32'd1);
    hif.Rs_E = 5'd0;
    #1 chk("fwd_r0", 32'(hif.ForwardA_E), 32'd0);
    cycle();

    // Load-use
    clear_inputs();
    set_load_use();
    #1;
    chk("lduse_StallF", 32'(hif.StallF), 32'd1);
    chk("lduse_StallD", 32'(hif.StallD), 32'd1);
    chk("lduse_FlushE", 32'(hif.FlushE), 32'd1);
    cycle();
    chk("lduse_hz", 32'(hif.hz_state), 32'd1);
    hif.WriteReg_E = 5'd0;
    #1 chk("lduse_r0_nostall", 32'(hif.StallF), 32'd0);
    cycle();

    // Branch stall suppresses the redirect flush
    clear_inputs();
    hif.Branch_D = 1'b1; hif.Rs_D = 5'd3; hif.RegWrite_E = 1'b1;
    hif.WriteReg_E = 5'd3; hif.PCSrc_D = 2'b01;
    #1;
    chk("br_StallD", 32'(hif.StallD), 32'd1);
    chk("br_FlushE", 32'(hif.FlushE), 32'd1);
    chk("br_FlushD", 32'(hif.FlushD), 32'd0);
    cycle();
    hif.RegWrite_E = 1'b0;
    #1;
    chk("br_rel_FlushD", 32'(hif.FlushD), 32'd1);
    chk("br_rel_StallD", 32'(hif.StallD), 32'd0);
    cycle();

    // Memory wait overrides load-use
    clear_inputs();
    do_reset();
    set_load_use();
    hif.dmem_wait_M = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    chk("mw_StallE", 32'(hif.StallE), 32'd1);
    chk("mw_StallM", 32'(hif.StallM), 32'd1);
    chk("mw_FlushW", 32'(hif.FlushW), 32'd1);
    chk("mw_FlushE", 32'(hif.FlushE), 32'd0);
    chk("mw_hz", 32'(hif.hz_state), 32'd3);
    hif.dmem_wait_M = 1'b0;
    cycle();
    chk("mw_after_hz", 32'(hif.hz_state), 32'd1);
    clear_inputs();
    cycle();

    // Watchdog: 3 waits do not trip, 4 consecutive waits do
    do_reset();
    hif.dmem_wait_M = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    chk("to_after3", 32'(hif.wait_timeout), 32'd0);
    hif.dmem_wait_M = 1'b0;
    cycle();
    hif.dmem_wait_M = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    chk("to_before4", 32'(hif.wait_timeout), 32'd0);
    cycle();
    chk("to_after4", 32'(hif.wait_timeout), 32'd1);
    hif.dmem_wait_M = 1'b0;
    cycle();
    chk("to_sticky", 32'(hif.wait_timeout), 32'd1);
    do_reset();
    chk("to_async_clear", 32'(hif.wait_timeout), 32'd0);

    // Performance counters: 2 load-use cycles then a jump
    clear_inputs();
    do_reset();
    set_load_use();
    cycle();
    cycle();
    clear_inputs();
    hif.PCSrc_D = 2'b10;
    cycle();
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_stalls", stall_cycles, 32'd2);
    chk("perf_flushes", 32'(flush_count), 32'd3);
`endif

    // Randomized traffic with small register ids so matches are frequent
    clear_inputs();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 79) == 0) do_reset();
      hif.Rs_D = 5'($urandom_range(0, 5));
      hif.Rt_D = 5'($urandom_range(0, 5));
      hif.Rs_E = 5'($urandom_range(0, 5));
      hif.Rt_E = 5'($urandom_range(0, 5));
      hif.WriteReg_E = 5'($urandom_range(0, 5));
      hif.WriteReg_M = 5'($urandom_range(0, 5));
      hif.WriteReg_W = 5'($urandom_range(0, 5));
      hif.RegWrite_E = 1'($urandom);
      hif.RegWrite_M = 1'($urandom);
      hif.RegWrite_W = 1'($urandom);
      hif.MemtoReg_E = 1'($urandom);
      hif.MemtoReg_M = 1'($urandom);
      hif.Branch_D = 1'($urandom);
      hif.PCSrc_D = 2'($urandom);
      hif.dmem_wait_M = ($urandom_range(0, 9) < 5);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
